mem_arbiter: RTL and testbench

//  Shares one single-ported memory between the CPU instruction-fetch port (I) and

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/arb_sat_counter.sv | 33 +++
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Brief    : Shared state and port-identifier encodings for the I/D memory
//             arbiter and the CPU top-level glue that observes it.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  // Arbiter FSM: idle -> waiting on memory -> one-cycle ack pulse -> idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Which CPU port owns the transaction currently in flight.
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

endpackage : mem_arbiter_pkg

`default_nettype wire

// File: rtl/arb_sat_counter.sv
// ============================================================================
//  Module   : arb_sat_counter
//  Brief    : Up-counter with synchronous clear that sticks at MAX.
//             Clear has priority over increment. MAX must be >= 1.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_sat_counter #(
  parameter  int MAX = 4,
  localparam int W   = $clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  // Count up until MAX, then hold; clear wins over increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != W'(MAX))) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule : arb_sat_counter

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Shares one single-ported, variable-latency memory between the
//             CPU instruction-fetch port (I) and load/store port (D).
//             D wins ties unless I has lost STARVE_MAX ties in a row.
//             A memory access that sees no ack for TIMEOUT cycles is aborted,
//             answered with zero data and flagged on the sticky err_o.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,    // >= 1
  parameter int TIMEOUT    = 255   // >= 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // instruction-fetch port
  input  logic              ireq_i,
  input  logic [ADDR_W-1:0] iaddr_i,
  output logic              iack_o,
  output logic [DATA_W-1:0] irdata_o,
  // data load/store port
  input  logic              dreq_i,
  input  logic              dwe_i,
  input  logic [ADDR_W-1:0] daddr_i,
  input  logic [DATA_W-1:0] dwdata_i,
  output logic              dack_o,
  output logic [DATA_W-1:0] drdata_o,
  // shared memory
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  // pipeline control / status
  output logic              stall_o,
  output logic              err_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t    r_state;
  arb_state_t    w_state_next;
  arb_port_t     r_port;

  logic [SW-1:0] w_starve_cnt;
  logic [TW-1:0] w_to_cnt;

  logic          w_grant;      // IDLE accepts a request this cycle
  logic          w_grant_i;    // ... and it is the fetch port
  logic          w_done;       // memory acked the access in flight
  logic          w_timeout;    // access abandoned, no ack in time
  logic          w_starve_inc;
  logic          w_starve_clr;
  logic          w_to_inc;

  // Consecutive tie losses of the fetch port; resets whenever I stops asking.
  assign w_starve_inc = w_grant & ~w_grant_i & ireq_i;
  assign w_starve_clr = ((r_state == ST_IDLE) & ~ireq_i) | (w_grant & w_grant_i);

  arb_sat_counter #(
    .MAX   (STARVE_MAX)
  ) u_starve_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (w_starve_clr),
    .inc_i (w_starve_inc),
    .cnt_o (w_starve_cnt)
  );

  // WAIT-cycle counter; restarted on every grant so each access gets a full budget.
  assign w_to_inc = (r_state == ST_WAIT);

  arb_sat_counter #(
    .MAX   (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (w_grant),
    .inc_i (w_to_inc),
    .cnt_o (w_to_cnt)
  );

  // The CPU stalls while either port has an unanswered request.
  assign stall_o = (ireq_i & ~iack_o) | (dreq_i & ~dack_o);

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and grant decision; an ack in the final WAIT cycle beats the timeout.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_i    = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ireq_i || dreq_i) begin
          w_grant      = 1'b1;
          w_grant_i    = ireq_i & (~dreq_i | (w_starve_cnt == SW'(STARVE_MAX)));
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          w_done       = 1'b1;
          w_state_next = ST_RESP;
        end else if (w_to_cnt == TW'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Memory-side request registers, returned data, ack pulses and the error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_port      <= PORT_I;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      iack_o      <= 1'b0;
      dack_o      <= 1'b0;
      irdata_o    <= '0;
      drdata_o    <= '0;
      err_o       <= 1'b0;
    end else begin
      iack_o <= 1'b0;
      dack_o <= 1'b0;

      if (w_grant) begin
        mem_req_o <= 1'b1;
        if (w_grant_i) begin
          r_port      <= PORT_I;
          mem_we_o    <= 1'b0;
          mem_addr_o  <= iaddr_i;
          mem_wdata_o <= '0;
        end else begin
          r_port      <= PORT_D;
          mem_we_o    <= dwe_i;
          mem_addr_o  <= daddr_i;
          mem_wdata_o <= dwdata_i;
        end
      end

      if (w_done || w_timeout) begin
        mem_req_o <= 1'b0;
        if (r_port == PORT_I) begin
          iack_o   <= 1'b1;
          irdata_o <= w_done ? mem_rdata_i : '0;
        end else begin
          dack_o <= 1'b1;
          if (!mem_we_o) begin
            drdata_o <= w_done ? mem_rdata_i : '0;
          end
        end
        if (w_timeout) begin
          err_o <= 1'b1;
        end
      end
    end
  end

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Scoreboard bench for mem_arbiter: port drivers push expected
//             responses, a negedge monitor pops and compares on every ack,
//             and a behavioural memory answers the shared-memory port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int M_RAND  = 0;  // memory acks after 1..4 WAIT cycles
  localparam int M_FIX   = 1;  // memory acks after fix_lat WAIT cycles
  localparam int M_NOACK = 2;  // memory never acks
  localparam int M_MAN   = 3;  // ack driven by hand from the main sequence

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } d_exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        ireq_i, dreq_i, dwe_i;
  logic [31:0] iaddr_i, daddr_i, dwdata_i;
  logic        iack_o, dack_o;
  logic [31:0] irdata_o, drdata_o;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        stall_o, err_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] i_exp[$];
  d_exp_t      d_exp[$];
  logic [31:0] mem_arr[logic [31:0]];  // contents of the memory model
  logic [31:0] ref_d[logic [31:0]];    // reference view of what stores left behind
  bit          grant_log[$];           // 0 = I, 1 = D, in grant order

  int          mode = M_RAND;
  int          fix_lat = 3;
  logic        man_ack = 1'b0;
  logic [31:0] man_data = 32'h0;
  int          req_len_last = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4),
    .TIMEOUT    (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .ireq_i      (ireq_i),
    .iaddr_i     (iaddr_i),
    .iack_o      (iack_o),
    .irdata_o    (irdata_o),
    .dreq_i      (dreq_i),
    .dwe_i       (dwe_i),
    .daddr_i     (daddr_i),
    .dwdata_i    (dwdata_i),
    .dack_o      (dack_o),
    .drdata_o    (drdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_d.exists(a) ? ref_d[a] : inst_of(a);
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
  endtask

  // Memory model: answers mem_req_o according to the current mode.
  initial begin
    int wcnt;
    int lat;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    wcnt = 0;
    lat  = 1;
    forever begin
      @(negedge clk);
      if (mode == M_MAN) begin
        mem_ack_i   = man_ack;
        mem_rdata_i = man_data;
        wcnt        = 0;
      end else if (mem_req_o && !mem_ack_i) begin
        wcnt++;
        if ((mode == M_RAND && wcnt >= lat) || (mode == M_FIX && wcnt >= fix_lat)) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_arr.exists(mem_addr_o) ? mem_arr[mem_addr_o] : inst_of(mem_addr_o);
          if (mem_we_o) mem_arr[mem_addr_o] = mem_wdata_o;
        end
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        if (!mem_req_o) begin
          wcnt = 0;
          lat  = $urandom_range(1, 4);
        end
      end
    end
  end

  // Monitor: checks every ack against the scoreboard plus the memory-side request.
  initial begin
    logic        prev_req, prev_iack, prev_dack, is_i, is_d, exp_stall;
    logic [31:0] last_load, e_i;
    d_exp_t      e_d;
    int          req_len;
    prev_req = 0; prev_iack = 0; prev_dack = 0; last_load = 0; req_len = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        prev_req = 0; prev_iack = 0; prev_dack = 0; last_load = 0; req_len = 0;
      end else begin
        exp_stall = (ireq_i & ~iack_o) | (dreq_i & ~dack_o);
        chk(stall_o == exp_stall, "stall", {31'd0, stall_o}, {31'd0, exp_stall});
        if (mem_req_o && !prev_req) begin
          is_i = ireq_i && !mem_we_o && (mem_addr_o == iaddr_i);
          is_d = dreq_i && (mem_addr_o == daddr_i) && (mem_we_o == dwe_i) &&
                 (!dwe_i || (mem_wdata_o == dwdata_i));
          chk(is_i || is_d, "memfields", mem_addr_o, is_i ? iaddr_i : daddr_i);
          grant_log.push_back(!is_i);
        end
        if (mem_req_o) req_len++;
        else if (prev_req) begin
          req_len_last = req_len;
          req_len      = 0;
        end
        if (iack_o || dack_o)
          chk(!(iack_o && dack_o), "ack_overlap", {30'd0, iack_o, dack_o}, 32'd0);
        if (iack_o) begin
          chk(!prev_iack, "iack_pulse", {31'd0, prev_iack}, 32'd0);
          if (i_exp.size() == 0) chk(1'b0, "iack_unexpected", irdata_o, 32'd0);
          else begin
            e_i = i_exp.pop_front();
            chk(irdata_o == e_i, "irdata", irdata_o, e_i);
          end
        end
        if (dack_o) begin
          chk(!prev_dack, "dack_pulse", {31'd0, prev_dack}, 32'd0);
          if (d_exp.size() == 0) chk(1'b0, "dack_unexpected", drdata_o, 32'd0);
          else begin
            e_d = d_exp.pop_front();
            if (e_d.we) chk(drdata_o == last_load, "drdata_store_hold", drdata_o, last_load);
            else begin
              chk(drdata_o == e_d.data, "drdata_load", drdata_o, e_d.data);
              last_load = e_d.data;
            end
          end
        end
        prev_req  = mem_req_o;
        prev_iack = iack_o;
        prev_dack = dack_o;
      end
    end
  end

  task automatic i_txn(input logic [31:0] a, input bit keep);
    int n;
    ireq_i  = 1'b1;
    iaddr_i = a;
    i_exp.push_back(ref_rd(a));
    n = 0;
    do begin @(negedge clk); n++; end while (!iack_o && n < 300);
    chk(iack_o == 1'b1, "iack_wait", {31'd0, iack_o}, 32'd1);
    @(posedge clk); #1;
    if (!keep) ireq_i = 1'b0;
  endtask

  task automatic d_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input bit keep, input bit zero);
    int     n;
    d_exp_t e;
    dreq_i   = 1'b1;
    dwe_i    = we;
    daddr_i  = a;
    dwdata_i = wd;
    e.we     = we;
    e.data   = zero ? 32'h0 : ref_rd(a);
    if (we && !zero) ref_d[a] = wd;
    d_exp.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!dack_o && n < 300);
    chk(dack_o == 1'b1, "dack_wait", {31'd0, dack_o}, 32'd1);
    @(posedge clk); #1;
    if (!keep) dreq_i = 1'b0;
  endtask

  task automatic i_run(input int n, input bit tie);
    int  gap;
    bit  keep;
    gap = 0;
    for (int k = 0; k < n; k++) begin
      repeat (gap) begin @(posedge clk); #1; end
      keep = (k < n - 1) && (tie || ($urandom_range(0, 1) == 1));
      i_txn(32'h1000 + 32'($urandom_range(0, 255)) * 4, keep);
      gap = (keep || tie) ? 0 : $urandom_range(1, 3);
    end
  endtask

  task automatic d_run(input int n, input bit tie);
    int  gap;
    bit  keep;
    gap = 0;
    for (int k = 0; k < n; k++) begin
      repeat (gap) begin @(posedge clk); #1; end
      keep = (k < n - 1) && (tie || ($urandom_range(0, 1) == 1));
      if (tie) d_txn(1'b0, 32'h2000 + 32'($urandom_range(0, 7)) * 4, 32'h0, keep, 1'b0);
      else     d_txn(1'($urandom_range(0, 1)), 32'h2000 + 32'($urandom_range(0, 7)) * 4,
                     $urandom, keep, 1'b0);
      gap = (keep || tie) ? 0 : $urandom_range(1, 3);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=%0d required=%0d", 1, 0);
    $fatal(1, "watchdog expired");
  end

  // Main sequence of directed and random phases.
  initial begin
    int          n;
    bit          exp_pat[6];
    exp_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    rst_i = 1'b1; ireq_i = 0; dreq_i = 0; dwe_i = 0;
    iaddr_i = 0; daddr_i = 0; dwdata_i = 0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(mem_req_o == 0, "rst_mem_req", {31'd0, mem_req_o}, 0);
    chk(mem_we_o == 0, "rst_mem_we", {31'd0, mem_we_o}, 0);
    chk(mem_addr_o == 0, "rst_mem_addr", mem_addr_o, 0);
    chk(!iack_o && !dack_o, "rst_acks", {30'd0, iack_o, dack_o}, 0);
    chk(err_o == 0, "rst_err", {31'd0, err_o}, 0);
    chk(irdata_o == 0 && drdata_o == 0, "rst_rdata", irdata_o | drdata_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // single fetch, memory answers in 3 cycles
    mode = M_FIX; fix_lat = 3;
    mem_arr[32'h100] = 32'h8C010004;
    ireq_i = 1'b1; iaddr_i = 32'h100;
    i_exp.push_back(32'h8C010004);
    @(negedge clk);
    chk(mem_req_o == 0, "fetch_req_n", {31'd0, mem_req_o}, 0);
    @(negedge clk);
    chk(mem_req_o == 1, "fetch_req_n1", {31'd0, mem_req_o}, 1);
    chk(mem_addr_o == 32'h100, "fetch_addr", mem_addr_o, 32'h100);
    n = 0;
    while (!iack_o && n < 50) begin @(negedge clk); n++; end
    chk(iack_o == 1, "fetch_ack", {31'd0, iack_o}, 1);
    chk(n == 3, "fetch_latency", n, 3);
    chk(stall_o == 0, "fetch_stall_ack", {31'd0, stall_o}, 0);
    @(posedge clk); #1;
    ireq_i = 1'b0;
    @(negedge clk);
    chk(iack_o == 0, "fetch_ack_drop", {31'd0, iack_o}, 0);
    chk(irdata_o == 32'h8C010004, "fetch_irdata_hold", irdata_o, 32'h8C010004);
    @(posedge clk); #1;

    // store then load
    mode = M_RAND;
    d_txn(1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 1'b0);
    d_txn(1'b0, 32'h200, 32'h0, 1'b0, 1'b0);
    chk(drdata_o == 32'hDEADBEEF, "load_after_store", drdata_o, 32'hDEADBEEF);

    // tie / starvation
    repeat (2) begin @(posedge clk); #1; end
    grant_log.delete();
    fork
      i_run(2, 1'b1);
      d_run(6, 1'b1);
    join
    chk(grant_log.size() >= 6, "tie_grants", grant_log.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < grant_log.size())
        chk(grant_log[k] == exp_pat[k], "tie_order", {31'd0, grant_log[k]}, {31'd0, exp_pat[k]});

    // randomized concurrent traffic
    repeat (2) begin @(posedge clk); #1; end
    fork
      i_run(40, 1'b0);
      d_run(40, 1'b0);
    join
    chk(err_o == 0, "no_err_random", {31'd0, err_o}, 0);

    // timeout on a load
    repeat (2) begin @(posedge clk); #1; end
    mode = M_NOACK;
    d_txn(1'b0, 32'h2040, 32'h0, 1'b0, 1'b1);
    chk(req_len_last == 8, "timeout_len", req_len_last, 8);
    chk(err_o == 1, "timeout_err", {31'd0, err_o}, 1);
    mode = M_RAND;
    d_txn(1'b0, 32'h2004, 32'h0, 1'b0, 1'b0);
    chk(err_o == 1, "err_sticky", {31'd0, err_o}, 1);

    // reset mid-WAIT, then a late ack
    mode = M_MAN;
    dreq_i = 1'b1; dwe_i = 1'b0; daddr_i = 32'h40;
    repeat (3) @(negedge clk);
    chk(mem_req_o == 1 && mem_addr_o == 32'h40, "rst_pre_wait", mem_addr_o, 32'h40);
    @(posedge clk); #1;
    rst_i = 1'b1; dreq_i = 1'b0;
    @(negedge clk);
    chk(mem_req_o == 0, "rst_mid_req", {31'd0, mem_req_o}, 0);
    chk(!iack_o && !dack_o, "rst_mid_acks", {30'd0, iack_o, dack_o}, 0);
    chk(err_o == 0, "rst_mid_err", {31'd0, err_o}, 0);
    @(posedge clk); #1;
    rst_i = 1'b0; man_ack = 1'b1; man_data = 32'h12345678;
    @(posedge clk); #1;
    man_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk(!mem_req_o && !dack_o && !iack_o, "late_ack_ignored",
          {29'd0, mem_req_o, dack_o, iack_o}, 0);
      chk(drdata_o == 0, "late_ack_drdata", drdata_o, 0);
    end
    @(posedge clk); #1;

    // ack on the exact timeout cycle
    mode = M_FIX; fix_lat = 8;
    d_txn(1'b0, 32'h2044, 32'h0, 1'b0, 1'b0);
    chk(req_len_last == 8, "collide_len", req_len_last, 8);
    chk(err_o == 0, "collide_err", {31'd0, err_o}, 0);

    repeat (3) begin @(posedge clk); #1; end
    chk(i_exp.size() == 0, "i_queue_drained", i_exp.size(), 0);
    chk(d_exp.size() == 0, "d_queue_drained", d_exp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_mem_arbiter

`default_nettype wire
